// File: rtl/irrigacao_pkg.sv
// irrigacao_pkg: shared state encoding, status codes and default timing for the irrigation controller
package irrigacao_pkg;
    localparam int NUM_BITS = 2;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int MAX_IRR_DEF = 16;
    localparam logic [NUM_BITS-1:0] U_DESLIGADO = 2'b00;
    localparam logic [NUM_BITS-1:0] U_IRRIGANDO = 2'b01;
    localparam logic [NUM_BITS-1:0] U_OCIOSO = 2'b10;
    localparam logic [NUM_BITS-1:0] U_ERRO = 2'b11;
    typedef enum logic [NUM_BITS-1:0] {
        DESLIGADO = U_DESLIGADO,
        IRRIGANDO = U_IRRIGANDO,
        OCIOSO = U_OCIOSO,
        ERRO = U_ERRO
    } estado_t;
endpackage

// File: rtl/filtro_sensor.sv
// filtro_sensor: two-flop synchronizer followed by a debounce filter; resets to wet
module filtro_sensor
    import irrigacao_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o
);
    logic [1:0] sync_q;
    logic [3:0] cnt_q, cnt_d;
    logic filt_q, filt_d, differ, done;

    always_comb begin
        differ = sync_q[1] != filt_q;
        done = differ && (cnt_q == 4'(DEB_CYCLES - 1));
        cnt_d = (differ && !done) ? cnt_q + 4'd1 : 4'd0;
        filt_d = done ? sync_q[1] : filt_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
            cnt_q <= 4'd0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;
endmodule

// File: rtl/controle_irrigacao.sv
// controle_irrigacao: moisture-driven valve FSM with irrigation timeout and latched fault
module controle_irrigacao
    import irrigacao_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int MAX_IRR = MAX_IRR_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                s_raso,
    input  logic                s_fundo,
    output logic [NUM_BITS-1:0] U,
    output logic                valvula
);
    estado_t state_q, state_d;
    logic [7:0] tmr_q, tmr_d;
    logic raso_f, fundo_f, seco, molhado, timeout;

    filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_raso (
        .clock(clock), .reset(reset), .raw_i(s_raso), .filt_o(raso_f)
    );
    filtro_sensor #(.DEB_CYCLES(DEB_CYCLES)) u_fundo (
        .clock(clock), .reset(reset), .raw_i(s_fundo), .filt_o(fundo_f)
    );

    always_comb begin
        seco = !raso_f && !fundo_f;
        molhado = raso_f && fundo_f;
        timeout = tmr_q == 8'(MAX_IRR - 1);
        tmr_d = (state_q != IRRIGANDO) ? 8'd0 : (tmr_q == 8'hFF) ? tmr_q : tmr_q + 8'd1;
        state_d = state_q;
        case (state_q)
            DESLIGADO: state_d = OCIOSO;
            OCIOSO:    state_d = seco ? IRRIGANDO : OCIOSO;
            // a simultaneous wet exit wins over the timeout
            IRRIGANDO: state_d = molhado ? OCIOSO : timeout ? ERRO : IRRIGANDO;
            ERRO:      state_d = ERRO;
            default:   state_d = DESLIGADO;
        endcase
        if (!enable) state_d = DESLIGADO;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DESLIGADO;
            tmr_q <= 8'd0;
        end else begin
            state_q <= state_d;
            tmr_q <= tmr_d;
        end
    end

    assign U = state_q;
    assign valvula = state_q == IRRIGANDO;
endmodule

// File: doc/controle_irrigacao.md
CONTROLE_IRRIGACAO -- requirements
Module: controle_irrigacao

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles required to accept a new sensor level (legal range 2..15).
REQ-002 Parameter MAX_IRR, default 16: maximum valve-on cycles before a fault is declared (legal range 2..255).
REQ-003 Port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port enable  input  1  1 = controller active; 0 = forced off.
REQ-006 Port s_raso  input  1  raw shallow moisture sensor, 1 = wet, asynchronous to clock, may bounce.
REQ-007 Port s_fundo  input  1  raw deep moisture sensor, 1 = wet, asynchronous to clock, may bounce.
REQ-008 Port U  output  2  status code for the downstream 7-segment status decoder.
REQ-009 Port valvula  output  1  irrigation valve drive, 1 = open.

Function
REQ-010 Each raw sensor SHALL pass through a two-flop synchronizer, then a debounce filter.
REQ-011 Filter: counter increments on each edge where the synchronized value differs from the filtered value, and clears on any edge where they are equal.
REQ-012 Filter: the filtered value SHALL take the synchronized value on the DEB_CYCLES-th consecutive differing edge; the counter clears on that same edge.
REQ-013 The FSM states SHALL be DESLIGADO, OCIOSO, IRRIGANDO and ERRO. Outputs are Moore-decoded from the registered state.
REQ-014 U SHALL be 00 in DESLIGADO, 01 in IRRIGANDO, 10 in OCIOSO and 11 in ERRO. valvula = 1 only in IRRIGANDO.
REQ-015 enable = 0 SHALL force the next state to DESLIGADO from any state, overriding every other condition.
REQ-016 DESLIGADO -> OCIOSO when enable = 1.
REQ-017 OCIOSO -> IRRIGANDO when both filtered sensors are 0; otherwise the FSM stays in OCIOSO (hysteresis: one dry sensor does not start irrigation).
REQ-018 IRRIGANDO -> OCIOSO when both filtered sensors are 1; one wet sensor does not stop irrigation.
REQ-019 Timeout counter: cleared on entry to IRRIGANDO, incremented on each edge spent in it. It SHALL saturate and never wrap.
REQ-020 IRRIGANDO -> ERRO when the timeout counter equals MAX_IRR-1 and the REQ-018 exit condition is false, so valvula is high for exactly MAX_IRR cycles.
REQ-021 If the exit condition and the timeout occur on the same edge, the FSM SHALL go to OCIOSO.
REQ-022 ERRO SHALL be latched regardless of sensor values and left only through enable = 0 or reset.
REQ-023 Latency: a filtered-sensor change SHALL be reflected in U and valvula one edge later.

Reset
REQ-024 reset = 1 SHALL, at the next rising edge, set the state to DESLIGADO (U = 00, valvula = 0).
REQ-025 The same reset SHALL set both filtered sensor values and synchronizer flops to 1 (wet), so no irrigation occurs before dryness is confirmed.
REQ-026 The same reset SHALL clear all debounce and timeout counters.
REQ-027 reset SHALL take priority over enable and all sensor conditions.
REQ-028 Asserting reset mid-irrigation SHALL close the valve at that edge.

Structure
REQ-029 Package irrigacao_pkg SHALL hold NUM_BITS = 2, the state enum, the four U code constants, and the defaults for DEB_CYCLES and MAX_IRR.
REQ-030 Sub-module filtro_sensor (synchronizer plus debounce, parameterized by DEB_CYCLES) SHALL be instantiated once per sensor.
REQ-031 The FSM and timeout counter SHALL reside in controle_irrigacao.

Verification
REQ-032 Reset then enable = 1, sensors wet: U = 00 during reset, 10 one edge after reset release, valvula = 0 throughout.
REQ-033 From OCIOSO, drive both sensors to 0 and hold: U = 01 and valvula = 1 exactly 2 + DEB_CYCLES + 1 edges (= 7) after the change; a 3-cycle glitch to 0 SHALL produce no change.
REQ-034 In IRRIGANDO, raise s_fundo only: stays 01; then raise s_raso: U = 10 after the filter latency plus 1 edge.
REQ-035 Hold both sensors dry in IRRIGANDO: valvula high for exactly 16 cycles, then U = 11. Wetting the sensors afterwards keeps U = 11; enable = 0 gives U = 00 next edge; enable = 1 gives U = 10 or 01 per sensors.
REQ-036 Exit condition first met on the timeout edge: U = 10, not 11.
REQ-037 Assert reset on cycle 5 of irrigation: valvula = 0 and U = 00 at that edge; after release with sensors dry, the valve reopens only after full filter latency.
